// File: rtl/fp_to_twos_decoder_pkg.sv
// fp_to_twos_decoder_pkg: shared widths and FSM encodings for the float-to-integer decoder.
package fp_to_twos_decoder_pkg;
    localparam int DEF_EXP_W  = 3;
    localparam int DEF_MANT_W = 4;
    localparam int DEF_OUT_W  = 12;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/fp_to_twos_decoder_if.sv
// fp_to_twos_decoder_if: float-word input and integer-sample output handshakes.
interface fp_to_twos_decoder_if #(
    parameter int EXP_W  = fp_to_twos_decoder_pkg::DEF_EXP_W,
    parameter int MANT_W = fp_to_twos_decoder_pkg::DEF_MANT_W,
    parameter int OUT_W  = fp_to_twos_decoder_pkg::DEF_OUT_W
);
    logic              in_valid;
    logic              in_ready;
    logic              s_in;
    logic [EXP_W-1:0]  e_in;
    logic [MANT_W-1:0] f_in;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  d_out;
    modport master (
        output in_valid, s_in, e_in, f_in, out_ready,
        input  in_ready, out_valid, d_out
    );
    modport slave (
        input  in_valid, s_in, e_in, f_in, out_ready,
        output in_ready, out_valid, d_out
    );
endinterface

// File: rtl/fp_to_twos_decoder_sm_to_twos.sv
// fp_to_twos_decoder_sm_to_twos: sign-magnitude to two's-complement, negative zero maps to zero.
module fp_to_twos_decoder_sm_to_twos #(
    parameter int W = fp_to_twos_decoder_pkg::DEF_OUT_W
) (
    input  logic         sgn_i,
    input  logic [W-2:0] mag_i,
    output logic [W-1:0] d_o
);
    always_comb d_o = (sgn_i && |mag_i) ? ~{1'b0, mag_i} + W'(1) : {1'b0, mag_i};
endmodule

// File: rtl/fp_to_twos_decoder.sv
// fp_to_twos_decoder: {S,E,F} float word to two's-complement (S ? -1 : 1) * (F << E),
// shifting one bit per clock.
module fp_to_twos_decoder
    import fp_to_twos_decoder_pkg::*;
#(
    parameter int EXP_W  = DEF_EXP_W,
    parameter int MANT_W = DEF_MANT_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input logic                  clk,
    input logic                  rst_n,
    fp_to_twos_decoder_if.slave  bus
);
    if (OUT_W < MANT_W + (1 << EXP_W)) begin : g_bad_width
        $error("OUT_W must be at least MANT_W + 2**EXP_W");
    end
    state_e             state_q, state_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-2:0]   mag_q, mag_d;
    logic               sgn_q, sgn_d;
    logic [OUT_W-1:0]   dout_q, dout_d, conv;
    logic               ovalid_q, ovalid_d;
    fp_to_twos_decoder_sm_to_twos #(.W(OUT_W)) u_conv (
        .sgn_i (sgn_q),
        .mag_i (mag_q),
        .d_o   (conv)
    );
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        sgn_d    = sgn_q;
        dout_d   = dout_q;
        ovalid_d = ovalid_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) begin
                sgn_d   = bus.s_in;
                cnt_d   = bus.e_in;
                mag_d   = {{(OUT_W-1-MANT_W){1'b0}}, bus.f_in};
                state_d = ST_SHIFT;
            end
            ST_SHIFT: if (cnt_q != '0) begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - EXP_W'(1);
            end else begin
                dout_d   = conv;
                ovalid_d = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: if (bus.out_ready) begin
                ovalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            sgn_q    <= 1'b0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            sgn_q    <= sgn_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
        end
    end
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = ovalid_q;
    assign bus.d_out     = dout_q;
endmodule
